// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use stalls,
// multi-cycle divider sequencing and exception flushes out of EXE.
module pipeline_stall_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  cpu_clk_50M,
   input  logic                  cpu_rst,
   input  logic [REG_ADDR_W-1:0] id_i_rs_addr,
   input  logic                  id_i_rs_re,
   input  logic [REG_ADDR_W-1:0] id_i_rt_addr,
   input  logic                  id_i_rt_re,
   input  logic                  exe_i_dm2rf,
   input  logic [REG_ADDR_W-1:0] exe_i_rfwa,
   input  logic                  exe_i_div_start,
   input  logic                  exe_i_flush_req,
   output logic                  stall_pc,
   output logic                  stall_ifid,
   output logic                  stall_idexe,
   output logic                  bubble_idexe,
   output logic                  bubble_exemem,
   output logic                  flush,
   output logic                  div_busy,
   output logic                  div_done,
   output logic [1:0]            dbg_state_o
);

   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;
   logic             div_stall;

   assign hazard = exe_i_dm2rf && (exe_i_rfwa != '0) &&
                   ((id_i_rs_re && (id_i_rs_addr == exe_i_rfwa)) ||
                    (id_i_rt_re && (id_i_rt_addr == exe_i_rfwa)));

   // A divide stalls from its start cycle in IDLE through the last busy cycle;
   // DIV_DONE deliberately ignores div_start so the finishing div moves on.
   assign div_stall = (state_q == DIV_BUSY) ||
                      ((state_q == IDLE) && exe_i_div_start);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (exe_i_flush_req) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (exe_i_div_start) begin
                  state_d = DIV_BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
            DIV_BUSY: begin
               if (cnt_q == '0) begin
                  state_d = DIV_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            DIV_DONE: state_d = IDLE;
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      stall_pc      = 1'b0;
      stall_ifid    = 1'b0;
      stall_idexe   = 1'b0;
      bubble_idexe  = 1'b0;
      bubble_exemem = 1'b0;
      flush         = 1'b0;
      div_busy      = 1'b0;
      div_done      = 1'b0;
      if (!cpu_rst) begin
         div_busy = (state_q == DIV_BUSY);
         div_done = (state_q == DIV_DONE);
         if (exe_i_flush_req) begin
            flush = 1'b1;
         end else if (div_stall) begin
            stall_pc      = 1'b1;
            stall_ifid    = 1'b1;
            stall_idexe   = 1'b1;
            bubble_exemem = 1'b1;
         end else if (hazard) begin
            // The load leaves EXE next edge, so a single NOP into ID/EXE suffices.
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            bubble_idexe = 1'b1;
         end
      end
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a cycle-level behavioural model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_pipeline_stall_ctrl;

   localparam int DIVC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_addr, rt_addr, rfwa;
   logic       rs_re, rt_re, dm2rf, div_start, flush_req;
   logic       stall_pc, stall_ifid, stall_idexe, bubble_idexe, bubble_exemem;
   logic       flush, div_busy, div_done;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: busy cycles still to come, and whether this is the done cycle.
   int m_busy_left = 0;
   bit m_done      = 1'b0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.DIV_CYCLES(DIVC), .REG_ADDR_W(5)) dut (
      .cpu_clk_50M     (clk),
      .cpu_rst         (rst),
      .id_i_rs_addr    (rs_addr),
      .id_i_rs_re      (rs_re),
      .id_i_rt_addr    (rt_addr),
      .id_i_rt_re      (rt_re),
      .exe_i_dm2rf     (dm2rf),
      .exe_i_rfwa      (rfwa),
      .exe_i_div_start (div_start),
      .exe_i_flush_req (flush_req),
      .stall_pc        (stall_pc),
      .stall_ifid      (stall_ifid),
      .stall_idexe     (stall_idexe),
      .bubble_idexe    (bubble_idexe),
      .bubble_exemem   (bubble_exemem),
      .flush           (flush),
      .div_busy        (div_busy),
      .div_done        (div_done),
      .dbg_state_o     (dbg_state)
   );

   function automatic logic [7:0] outs();
      return {stall_pc, stall_ifid, stall_idexe, bubble_idexe,
              bubble_exemem, flush, div_busy, div_done};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle model compare, then advance the model with the same inputs.
   always @(negedge clk) begin
      logic [7:0] exp_v;
      bit haz, e_sp, e_sif, e_sie, e_bie, e_bem, e_fl, e_db, e_dd;
      haz = dm2rf && (rfwa != 0) &&
            ((rs_re && rs_addr == rfwa) || (rt_re && rt_addr == rfwa));
      {e_sp, e_sif, e_sie, e_bie, e_bem, e_fl, e_db, e_dd} = 8'h00;
      if (rst !== 1'b0) begin
         exp_v = 8'h00;
      end else begin
         e_db = (m_busy_left > 0);
         e_dd = m_done;
         if (flush_req) begin
            e_fl = 1'b1;
         end else if (m_busy_left > 0 || (!m_done && div_start)) begin
            {e_sp, e_sif, e_sie, e_bem} = 4'hF;
         end else if (haz) begin
            {e_sp, e_sif, e_bie} = 3'b111;
         end
         exp_v = {e_sp, e_sif, e_sie, e_bie, e_bem, e_fl, e_db, e_dd};
      end
      chk("model_outputs", {24'd0, outs()}, {24'd0, exp_v});
      if (rst !== 1'b0 || flush_req) begin
         m_busy_left = 0;
         m_done      = 1'b0;
      end else if (m_busy_left > 0) begin
         m_busy_left--;
         m_done = (m_busy_left == 0);
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (div_start) begin
         m_busy_left = DIVC;
      end
   end

   task automatic clear_inputs();
      rs_addr = 0; rt_addr = 0; rfwa = 0;
      rs_re = 0; rt_re = 0; dm2rf = 0; div_start = 0; flush_req = 0;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic run_quiet(input int cycles, input string name);
      bit saw_done = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         mid();
         if (div_done) saw_done = 1'b1;
         next();
      end
      chk(name, {31'd0, saw_done}, 32'd0);
   endtask

   task automatic wait_done(input int budget, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         mid();
         if (div_done) seen = 1'b1;
         next();
      end
      chk(name, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      int stall_cnt, busy_cnt, done_cyc;
      bit seen_done;

      clear_inputs();
      rst = 1'b1;
      div_start = 1'b1;
      dm2rf = 1'b1; rfwa = 5'd3; rs_re = 1'b1; rs_addr = 5'd3;
      mid();
      chk("reset_outputs_zero", {24'd0, outs()}, 32'd0);
      next(); next();
      rst = 1'b0;
      clear_inputs();
      mid();
      chk("idle_after_reset", {24'd0, outs()}, 32'd0);
      next();

      // Load-use on rs
      dm2rf = 1; rfwa = 5'd8; rs_re = 1; rs_addr = 5'd8;
      mid();
      chk("lu_rs_stall_set", {29'd0, stall_pc, stall_ifid, bubble_idexe}, 32'd7);
      chk("lu_rs_no_stall_idexe", {31'd0, stall_idexe}, 32'd0);
      next();
      clear_inputs();
      mid();
      chk("lu_rs_released", {24'd0, outs()}, 32'd0);
      next();

      // $0 destination never hazards; an unread rt does not hazard; a read rt does
      dm2rf = 1; rfwa = 5'd0; rs_re = 1; rs_addr = 5'd0;
      mid();
      chk("lu_zero_reg", {31'd0, stall_pc}, 32'd0);
      next();
      clear_inputs();
      dm2rf = 1; rfwa = 5'd9; rt_addr = 5'd9; rt_re = 0;
      mid();
      chk("lu_rt_not_read", {31'd0, stall_pc}, 32'd0);
      next();
      rt_re = 1;
      mid();
      chk("lu_rt_read", {24'd0, outs()}, 32'h000000D0);
      next();
      clear_inputs();

      // Divide held until done
      div_start = 1;
      stall_cnt = 0; busy_cnt = 0; done_cyc = 0; seen_done = 0;
      for (int c = 1; c <= 20 && !seen_done; c++) begin
         mid();
         if (stall_idexe) stall_cnt++;
         if (div_busy) busy_cnt++;
         if (div_done) begin
            seen_done = 1;
            done_cyc  = c;
            chk("div_done_no_stall", {29'd0, stall_pc, stall_ifid, stall_idexe}, 32'd0);
         end
         next();
      end
      chk("div_done_seen", {31'd0, seen_done}, 32'd1);
      chk("div_stall_cycles", stall_cnt, 32'd5);
      chk("div_busy_cycles", busy_cnt, 32'd4);
      chk("div_done_cycle", done_cyc, 32'd6);
      div_start = 0;
      mid();
      chk("div_idle_after", {24'd0, outs()}, 32'd0);
      next();

      // Flush in the 2nd busy cycle
      div_start = 1;
      next(); next();
      flush_req = 1;
      mid();
      chk("flush_mid_div", {24'd0, outs()}, 32'h00000006);
      next();
      clear_inputs();
      mid();
      chk("flush_div_busy_cleared", {31'd0, div_busy}, 32'd0);
      next();
      run_quiet(8, "flush_no_div_done");

      // div_start together with a matching load-use
      div_start = 1; dm2rf = 1; rfwa = 5'd8; rs_re = 1; rs_addr = 5'd8;
      mid();
      chk("div_over_lu", {24'd0, outs()}, 32'h000000E8);
      next();
      clear_inputs();
      flush_req = 1;
      next();
      clear_inputs();

      // div_start together with flush
      div_start = 1; flush_req = 1;
      mid();
      chk("flush_over_start", {24'd0, outs()}, 32'h00000004);
      next();
      flush_req = 0;
      mid();
      chk("start_not_taken", {30'd0, div_busy, stall_pc}, 32'd1);
      next();
      wait_done(20, "div_after_flush_done");
      clear_inputs();

      // Reset mid-divide
      div_start = 1;
      next(); next();
      rst = 1;
      mid();
      chk("rst_mid_div_zero", {24'd0, outs()}, 32'd0);
      next();
      rst = 0;
      clear_inputs();
      mid();
      chk("rst_mid_div_idle", {24'd0, outs()}, 32'd0);
      next();
      run_quiet(8, "rst_no_div_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
